// File: rtl/i2s_rx_frame_ctrl.sv
// i2s_rx_frame_ctrl: I2S receive frame sequencer delivering stereo sample pairs on valid/ready.
// Define I2S_RX_LJ_EN to add lj_i (left-justified timing, no 1-bit WS delay).
module i2s_rx_frame_ctrl #(
   parameter int DATA_W  = 24,
   parameter int CNT_RES = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              sck_i,
   input  logic              ws_i,
   input  logic              sd_i,
`ifdef I2S_RX_LJ_EN
   input  logic              lj_i,
`endif
   output logic [DATA_W-1:0] data_l_o,
   output logic [DATA_W-1:0] data_r_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              ovf_o,
   input  logic              clr_ovf_i,
   output logic              busy_o
);
   typedef enum logic [1:0] {ALIGN, SHIFT, HOLD} state_t;
   state_t state, state_nx;
   logic [2:0] sck_s;
   logic [1:0] ws_s, sd_s;
   logic ws_prev, chan, lj, sck_rise, ws_edge, new_slot, latch, complete;
   logic [CNT_RES-1:0] cnt;
   logic [DATA_W-1:0] sreg, sh, word, word_l;
`ifdef I2S_RX_LJ_EN
   assign lj = lj_i;
`else
   assign lj = 1'b0;
`endif
   assign sck_rise = sck_s[1] & ~sck_s[2];
   assign ws_edge  = sck_rise & (ws_s[1] != ws_prev);
   assign sh       = {sreg[DATA_W-2:0], sd_s[1]};
   // ALIGN only leaves on a falling WS edge, so every pair starts with a left slot
   assign new_slot = en_i & ws_edge & ((state != ALIGN) | ~ws_s[1]);
   assign latch    = en_i & sck_rise & (state == SHIFT) & (ws_edge | (cnt == CNT_RES'(DATA_W - 1)));
   assign complete = latch & chan;
   // MSB-align short words; in LJ mode the edge bit already belongs to the next slot
   assign word = (ws_edge & lj) ? sreg << (DATA_W - int'(cnt)) : sh << (DATA_W - 1 - int'(cnt));
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= ALIGN;
      else state <= state_nx;
   always_comb
      state_nx = !en_i ? ALIGN : new_slot ? SHIFT : latch ? HOLD : state;
   always_comb
      busy_o = (state != ALIGN);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         sck_s   <= '0;
         ws_s    <= '0;
         sd_s    <= '0;
         ws_prev <= 1'b0;
         chan    <= 1'b0;
         cnt     <= '0;
         sreg    <= '0;
         word_l  <= '0;
      end else begin
         sck_s <= {sck_s[1:0], sck_i};
         ws_s  <= {ws_s[0], ws_i};
         sd_s  <= {sd_s[0], sd_i};
         if (sck_rise) ws_prev <= ws_s[1];
         if (sck_rise & en_i) sreg <= sh;
         if (latch & ~chan) word_l <= word;
         if (new_slot) chan <= ws_s[1];
         if (!en_i) cnt <= '0;
         else if (new_slot) cnt <= lj ? CNT_RES'(1) : '0;
         else if (sck_rise & (state != ALIGN) & ~&cnt) cnt <= cnt + CNT_RES'(1);
      end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         data_l_o <= '0;
         data_r_o <= '0;
         valid_o  <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         if (complete & ~(valid_o & ~ready_i)) begin
            data_l_o <= word_l;
            data_r_o <= word;
            valid_o  <= 1'b1;
         end else if (valid_o & ready_i) valid_o <= 1'b0;
         if (complete & valid_o & ~ready_i) ovf_o <= 1'b1;
         else if (clr_ovf_i) ovf_o <= 1'b0;
      end
endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// tb_i2s_rx_frame_ctrl: randomized and directed I2S streams checked against a slot-decoding model.
module tb_i2s_rx_frame_ctrl;
   localparam int DW = 24;
   logic clk_i = 1'b0, rst_ni = 1'b1, en_i = 1'b0, sck_i = 1'b0, ws_i = 1'b0, sd_i = 1'b0;
   logic ready_i = 1'b0, clr_ovf_i = 1'b0;
`ifdef I2S_RX_LJ_EN
   logic lj_i = 1'b0;
`endif
   logic [DW-1:0] data_l_o, data_r_o, last_l, last_r, p1l, p1r, pal, par;
   logic valid_o, ovf_o, busy_o;
   logic [2*DW-1:0] exp_pair;
   int n_chk = 0, n_pass = 0, cyc = 0, xfers = 0, vr_cyc = 0, x0, nf;
   bit mon_en = 1'b0, vprev = 1'b0, last_ws = 1'b0;
   bit wsq[$], bitq[$];
   int rise_cyc[$];
   logic [2*DW-1:0] expq[$];

   i2s_rx_frame_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
`ifdef I2S_RX_LJ_EN
      .lj_i(lj_i),
`endif
      .data_l_o(data_l_o), .data_r_o(data_r_o), .valid_o(valid_o), .ready_i(ready_i),
      .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // consumer side: every transfer is compared against the model's pair queue
   always @(negedge clk_i) begin
      if (valid_o && !vprev) vr_cyc <= cyc;
      vprev <= valid_o;
      if (valid_o && ready_i) begin
         xfers  <= xfers + 1;
         last_l <= data_l_o;
         last_r <= data_r_o;
         if (mon_en) begin
            exp_pair = ~{data_l_o, data_r_o};
            if (expq.size() != 0) exp_pair = expq.pop_front();
            chk("pair", {data_l_o, data_r_o}, exp_pair);
         end
      end
   end

   task automatic push_slot(input bit ws, input logic [31:0] val, input int len);
      for (int i = 0; i < len; i++) begin
         wsq.push_back(ws);
         bitq.push_back(val[31-i]);
      end
   endtask

   function automatic logic [DW-1:0] slot_word(input int s, input int len);
      logic [DW-1:0] w = '0;
      for (int i = 0; i < DW; i++) w = {w[DW-2:0], (i < len) ? bitq[s+i] : 1'b0};
      return w;
   endfunction

   // a slot is a run of equal WS; pairing starts at the first left run entered from WS=1
   task automatic model();
      int s = 0;
      bit prev = last_ws, aligned = 1'b0;
      logic [DW-1:0] wl = '0;
      while (s < wsq.size()) begin
         int e = s;
         while (e < wsq.size() && wsq[e] == wsq[s]) e++;
         if (!wsq[s] && prev) aligned = 1'b1;
         if (aligned && e < wsq.size()) begin
            if (wsq[s]) expq.push_back({wl, slot_word(s, e - s)});
            else wl = slot_word(s, e - s);
         end
         prev = wsq[s];
         s = e;
      end
   endtask

   // d = delay of SD behind WS in SCK periods (1 for I2S, 0 for left-justified)
   task automatic play(input int d);
      rise_cyc.delete();
      for (int i = 0; i < wsq.size(); i++) begin
         @(negedge clk_i);
         sck_i = 1'b0;
         ws_i  = wsq[i];
         sd_i  = (i >= d) ? bitq[i-d] : 1'b0;
         repeat (4) @(negedge clk_i);
         sck_i = 1'b1;
         rise_cyc.push_back(cyc);
         repeat (3) @(negedge clk_i);
      end
      @(negedge clk_i);
      sck_i = 1'b0;
      repeat (12) @(negedge clk_i);
      last_ws = wsq[wsq.size()-1];
   endtask

   task automatic run(input int d);
      en_i = 1'b0;
      repeat (2) @(negedge clk_i);
      en_i = 1'b1;
      if (mon_en) model();
      play(d);
      if (mon_en) chk("pairs left", expq.size(), 0);
      expq.delete();
      wsq.delete();
      bitq.delete();
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk_i);
      #1 ready_i = v;
   endtask

   initial begin
      #1 rst_ni = 1'b0;
      #2;
      chk("rst valid", valid_o, 0);
      chk("rst data_l", data_l_o, 0);
      chk("rst data_r", data_r_o, 0);
      chk("rst ovf", ovf_o, 0);
      chk("rst busy", busy_o, 0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      set_ready(1'b1);
      mon_en = 1'b1;
      // one frame preceded by a right slot that must be ignored
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, {24'hA5A5A5, 8'h00}, 32);
      push_slot(1'b1, {24'h5A5A5A, 8'h00}, 32);
      push_slot(1'b0, 0, 2);
      x0 = xfers;
      run(1);
      chk("one pulse", xfers - x0, 1);
      chk("frame left", last_l, 24'hA5A5A5);
      chk("frame right", last_r, 24'h5A5A5A);
      chk("valid latency", vr_cyc - rise_cyc[64 + DW], 3);
      chk("busy in slot", busy_o, 1);
      en_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("en low busy", busy_o, 0);
      // short 16-bit slots and long slots with trailing ones
      push_slot(1'b1, $urandom, 16);
      push_slot(1'b0, 32'hBEEF0000, 16);
      push_slot(1'b1, 32'h12340000, 16);
      push_slot(1'b0, 0, 2);
      run(1);
      chk("short left", last_l, 24'hBEEF00);
      chk("short right", last_r, 24'h123400);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 32'h123456FF, 32);
      push_slot(1'b1, 32'hABCDEFFF, 32);
      push_slot(1'b0, 0, 2);
      run(1);
      chk("trail left", last_l, 24'h123456);
      chk("trail right", last_r, 24'hABCDEF);
      for (int k = 0; k < 6; k++) begin
         push_slot(1'b1, $urandom, $urandom_range(8, 32));
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
            push_slot(1'b0, $urandom, $urandom_range(8, 32));
            push_slot(1'b1, $urandom, $urandom_range(8, 32));
         end
         push_slot(1'b0, 0, 2);
         run(1);
      end
      // backpressure across two frames: first pair held, second dropped as overrun
      set_ready(1'b0);
      mon_en = 1'b0;
      p1l = DW'($urandom);
      p1r = DW'($urandom);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, {p1l, 8'h00}, 32);
      push_slot(1'b1, {p1r, 8'h00}, 32);
      push_slot(1'b0, $urandom, 32);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 0, 2);
      run(1);
      chk("ovf valid", valid_o, 1);
      chk("ovf hold l", data_l_o, p1l);
      chk("ovf hold r", data_r_o, p1r);
      chk("ovf set", ovf_o, 1);
      @(negedge clk_i) clr_ovf_i = 1'b1;
      @(negedge clk_i) clr_ovf_i = 1'b0;
      chk("ovf clear", ovf_o, 0);
      chk("ovf still valid", valid_o, 1);
      x0 = xfers;
      set_ready(1'b1);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("drain valid", valid_o, 0);
      chk("drain count", xfers - x0, 1);
      chk("drain left", last_l, p1l);
      // asynchronous reset while a pair is held and a slot is in progress
      set_ready(1'b0);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, {p1l, 8'h00}, 32);
      push_slot(1'b1, {p1r, 8'h00}, 32);
      push_slot(1'b0, $urandom, 10);
      run(1);
      chk("pre-rst valid", valid_o, 1);
      chk("pre-rst busy", busy_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async valid", valid_o, 0);
      chk("async busy", busy_o, 0);
      chk("async data_l", data_l_o, 0);
      chk("async data_r", data_r_o, 0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      last_ws = 1'b0;
      set_ready(1'b1);
      mon_en = 1'b1;
      pal = DW'($urandom);
      par = DW'($urandom);
      x0 = xfers;
      push_slot(1'b0, $urandom, 32);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, {pal, 8'h00}, 32);
      push_slot(1'b1, {par, 8'h00}, 32);
      push_slot(1'b0, 0, 2);
      run(1);
      chk("realign count", xfers - x0, 1);
      chk("realign left", last_l, pal);
      chk("realign right", last_r, par);
`ifdef I2S_RX_LJ_EN
      lj_i = 1'b1;
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 32'h80000100, 32);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 0, 2);
      run(0);
      chk("lj left", last_l, 24'h800001);
      lj_i = 1'b0;
      mon_en = 1'b0;
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 32'h80000100, 32);
      push_slot(1'b1, $urandom, 32);
      push_slot(1'b0, 0, 2);
      run(0);
      chk("lj as i2s", last_l, 24'h000002);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
